// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: linear fetch with stall, jump/branch redirect with a
// configurable flush bubble, and a halt once PC_LIMIT has been fetched.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT     = 32'h0000_00FC,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        HALT   = 2'd3
    } state_t;

    // The counter holds remaining bubbles minus one, so BUBBLE lasts exactly FLUSH_CYCLES.
    localparam logic [2:0] BUB_LOAD = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : '0;

    state_t      state, state_n;
    logic [31:0] pc_n;
    logic [15:0] cnt_n;
    logic [2:0]  bub_cnt, bub_n;
    logic        redirect;
    logic [31:0] target;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            fetch_cnt <= '0;
            bub_cnt   <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            fetch_cnt <= cnt_n;
            bub_cnt   <= bub_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        cnt_n    = fetch_cnt;
        bub_n    = bub_cnt;
        redirect = ((state == RUN) || (state == BUBBLE)) && (jump || branch_taken);
        target   = jump ? jump_target : branch_target;

        if (redirect) begin
            pc_n    = {target[31:2], 2'b00};
            bub_n   = BUB_LOAD;
            state_n = (FLUSH_CYCLES == 0) ? RUN : BUBBLE;
        end else begin
            case (state)
                IDLE: begin
                    pc_n = RESET_PC;
                    if (start) state_n = RUN;
                end
                RUN: begin
                    if (!stall) begin
                        if (fetch_cnt != '1) cnt_n = fetch_cnt + 16'd1;
                        if (pc == PC_LIMIT) state_n = HALT;
                        else                pc_n    = pc + 32'd4;
                    end
                end
                BUBBLE: begin
                    if (bub_cnt == '0) state_n = RUN;
                    else               bub_n   = bub_cnt - 3'd1;
                end
                HALT: begin
                    pc_n = PC_LIMIT;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign flush    = redirect;
    assign pc_valid = (state == RUN);
    assign halted   = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters (FLUSH_CYCLES=2, PC_LIMIT=0xFC).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc;
    logic        pc_valid, flush, halted;
    logic [15:0] fetch_cnt;

    int unsigned total = 0;
    int unsigned fails = 0;

    pc_sequencer u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .flush        (flush),
        .halted       (halted),
        .fetch_cnt    (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full output snapshot: pc, pc_valid, flush, halted, fetch_cnt
    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_v,
                           input logic e_f, input logic e_h, input logic [15:0] e_cnt);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(e_v));
        chk({tag, ".flush"}, 32'(flush), 32'(e_f));
        chk({tag, ".halted"}, 32'(halted), 32'(e_h));
        chk({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'(e_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        jump = 1'b0;
        branch_taken = 1'b0;
        jump_target = '0;
        branch_target = '0;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        clear_redirects();
        #1;
        chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_all("idle_hold", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Linear run, with a 3-cycle stall at 0x10
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("run_first", 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("run_pc", pc, 32'(i * 4));
            chk("run_cnt", 32'(fetch_cnt), 32'(i));
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("stall", 32'h10, 1'b1, 1'b0, 1'b0, 16'd4);
        end
        stall = 1'b0;
        tick();
        chk_all("stall_release", 32'h14, 1'b1, 1'b0, 1'b0, 16'd5);
        for (int i = 6; i <= 63; i++) begin
            tick();
            chk("lin_pc", pc, 32'(i * 4));
            chk("lin_cnt", 32'(fetch_cnt), 32'(i));
        end
        chk_all("at_limit", 32'hFC, 1'b1, 1'b0, 1'b0, 16'd63);
        tick();
        chk_all("halt", 32'hFC, 1'b0, 1'b0, 1'b1, 16'd64);

        // Redirect and start in HALT are ignored
        jump = 1'b1;
        jump_target = 32'h40;
        start = 1'b1;
        #1;
        chk("halt_flush", 32'(flush), 32'd0);
        tick();
        chk_all("halt_stays", 32'hFC, 1'b0, 1'b0, 1'b1, 16'd64);
        clear_redirects();
        start = 1'b0;

        // Async reset out of HALT
        #2;
        rst = 1'b0;
        #1;
        chk_all("halt_reset", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // Redirect in IDLE is ignored
        jump = 1'b1;
        jump_target = 32'h80;
        #1;
        chk("idle_flush", 32'(flush), 32'd0);
        tick();
        chk_all("idle_redirect", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        clear_redirects();

        // Simultaneous jump + branch under stall: jump wins
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_all("pre_redir", 32'h4, 1'b1, 1'b0, 1'b0, 16'd1);
        stall = 1'b1;
        jump = 1'b1;
        jump_target = 32'h40;
        branch_taken = 1'b1;
        branch_target = 32'h80;
        #1;
        chk("redir_flush", 32'(flush), 32'd1);
        tick();
        clear_redirects();
        #1;
        chk_all("bubble1", 32'h40, 1'b0, 1'b0, 1'b0, 16'd1);
        tick();
        chk_all("bubble2", 32'h40, 1'b0, 1'b0, 1'b0, 16'd1);
        stall = 1'b0;
        tick();
        chk_all("redir_run", 32'h40, 1'b1, 1'b0, 1'b0, 16'd1);
        tick();
        chk_all("redir_next", 32'h44, 1'b1, 1'b0, 1'b0, 16'd2);

        // Re-redirect in bubble cycle 1 restarts the bubble count
        branch_taken = 1'b1;
        branch_target = 32'h20;
        #1;
        chk("br1_flush", 32'(flush), 32'd1);
        tick();
        branch_target = 32'h30;
        #1;
        chk_all("rebub_flush", 32'h20, 1'b0, 1'b1, 1'b0, 16'd2);
        tick();
        clear_redirects();
        #1;
        chk_all("rebub1", 32'h30, 1'b0, 1'b0, 1'b0, 16'd2);
        tick();
        chk_all("rebub2", 32'h30, 1'b0, 1'b0, 1'b0, 16'd2);
        tick();
        chk_all("rebub_run", 32'h30, 1'b1, 1'b0, 1'b0, 16'd2);
        tick();
        chk_all("rebub_next", 32'h34, 1'b1, 1'b0, 1'b0, 16'd3);

        // Misaligned jump target is word-aligned
        jump = 1'b1;
        jump_target = 32'h23;
        tick();
        clear_redirects();
        #1;
        chk_all("mis_bub1", 32'h20, 1'b0, 1'b0, 1'b0, 16'd3);
        tick();
        chk_all("mis_bub2", 32'h20, 1'b0, 1'b0, 1'b0, 16'd3);
        tick();
        chk_all("mis_run", 32'h20, 1'b1, 1'b0, 1'b0, 16'd3);

        // Async reset mid-period during BUBBLE
        jump = 1'b1;
        jump_target = 32'h60;
        tick();
        clear_redirects();
        #1;
        chk_all("pre_areset", 32'h60, 1'b0, 1'b0, 1'b0, 16'd3);
        #1;
        rst = 1'b0;
        #1;
        chk_all("areset", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("post_reset_idle", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("restart", 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
        tick();
        chk_all("restart_next", 32'h4, 1'b1, 1'b0, 1'b0, 16'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
